// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO that launches one byte at a time into a UART
//               transmitter, waiting for each end-of-frame before the next.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Wr_DV,
    input  logic [7:0]        i_Wr_Byte,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2
    } state_t;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    state_t            state;
    logic              tx_dv;
    logic [7:0]        tx_byte;
    logic              overflow;
    logic              full;
    logic              empty;
    logic              wr_accept;
    logic              pop;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign wr_accept = i_Wr_DV && !full;
    // A write arriving while full is dropped even if a pop frees a slot this cycle.
    assign pop       = (state == IDLE) && !empty && !i_Tx_Active;

    assign o_Full     = full;
    assign o_Empty    = empty;
    assign o_Count    = count;
    assign o_Overflow = overflow;
    assign o_Tx_DV    = tx_dv;
    assign o_Tx_Byte  = tx_byte;

    always_ff @(posedge i_Clock) begin
        if (wr_accept) begin
            mem[wr_ptr] <= i_Wr_Byte;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= i_Wr_DV && full;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            unique case ({wr_accept, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state   <= IDLE;
            rd_ptr  <= '0;
            tx_dv   <= 1'b0;
            tx_byte <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    tx_dv <= 1'b0;
                    if (pop) begin
                        tx_byte <= mem[rd_ptr];
                        tx_dv   <= 1'b1;
                        rd_ptr  <= rd_ptr + ADDR_W'(1);
                        state   <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    tx_dv <= 1'b0;
                    if (i_Tx_Done) begin
                        state <= GAP;
                    end
                end
                // One settling cycle so the transmitter is idle before the next strobe.
                GAP: begin
                    tx_dv <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    tx_dv <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Scoreboard bench for uart_tx_fifo with a simple transmitter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst;
    logic              wr_dv;
    logic [7:0]        wr_byte;
    logic              o_Full;
    logic              o_Empty;
    logic [ADDR_W:0]   o_Count;
    logic              o_Overflow;
    logic              o_Tx_DV;
    logic [7:0]        o_Tx_Byte;
    logic              tx_active;
    logic              tx_done;

    // Transmitter inputs come either from the frame model or from directed steps.
    logic auto_en;
    logic man_active;
    logic man_done;
    logic m_active;
    logic m_done;
    logic m_busy;
    int   m_cnt;
    int   frame_len;

    assign tx_active = auto_en ? m_active : man_active;
    assign tx_done   = auto_en ? m_done   : man_done;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Wr_DV     (wr_dv),
        .i_Wr_Byte   (wr_byte),
        .o_Full      (o_Full),
        .o_Empty     (o_Empty),
        .o_Count     (o_Count),
        .o_Overflow  (o_Overflow),
        .o_Tx_DV     (o_Tx_DV),
        .o_Tx_Byte   (o_Tx_Byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] q[$];
    int   n_tests;
    int   n_fail;
    int   mcount;
    int   cycle;
    int   dv_total;
    int   acc_total;
    int   last_dv_tick;
    int   last_done_tick;
    int   wr_tick;
    int   base;
    logic prev_dv;
    logic gap_chk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard push before the edge, observe and model after it.
    task automatic tick();
        logic       acc;
        logic       ovf_exp;
        logic [7:0] exp_b;
        acc     = !rst && wr_dv && (mcount < DEPTH);
        ovf_exp = !rst && wr_dv && (mcount == DEPTH);
        if (acc) begin
            q.push_back(wr_byte);
            acc_total++;
        end
        @(posedge clk);
        #1;
        cycle++;
        if (acc) mcount++;
        if (o_Tx_DV) begin
            dv_total++;
            check("dv_back_to_back", int'(prev_dv), 0);
            check("dv_has_data", int'(q.size() != 0), 1);
            if (q.size() != 0) begin
                exp_b = q.pop_front();
                check("dv_byte", int'(o_Tx_Byte), int'(exp_b));
                mcount--;
            end
            if (gap_chk && last_done_tick >= 0)
                check("dv_after_done", cycle - last_done_tick, 3);
            last_dv_tick = cycle;
            if (auto_en) begin
                m_busy   = 1'b1;
                m_active = 1'b1;
                m_cnt    = frame_len;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy         = 1'b0;
                m_active       = 1'b0;
                m_done         = 1'b1;
                last_done_tick = cycle;
            end
        end
        prev_dv = o_Tx_DV;
        check("count", int'(o_Count), mcount);
        check("empty", int'(o_Empty), int'(mcount == 0));
        check("full", int'(o_Full), int'(mcount == DEPTH));
        check("overflow", int'(o_Overflow), int'(ovf_exp));
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_dv   = 1'b1;
        wr_byte = b;
        tick();
        wr_dv   = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while ((q.size() != 0 || m_busy || m_done) && k < budget) begin
            tick();
            k++;
        end
        check("drain_timeout", q.size(), 0);
        repeat (4) tick();
    endtask

    // Reset lands between clock edges; outputs must clear without waiting for an edge.
    task automatic async_reset();
        #3 rst = 1'b1;
        #1;
        check("rst_tx_dv", int'(o_Tx_DV), 0);
        check("rst_tx_byte", int'(o_Tx_Byte), 0);
        check("rst_count", int'(o_Count), 0);
        check("rst_empty", int'(o_Empty), 1);
        check("rst_full", int'(o_Full), 0);
        check("rst_overflow", int'(o_Overflow), 0);
        q.delete();
        mcount  = 0;
        prev_dv = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; wr_dv = 1'b0; wr_byte = 8'h00;
        auto_en = 1'b0; man_active = 1'b0; man_done = 1'b0;
        m_active = 1'b0; m_done = 1'b0; m_busy = 1'b0; m_cnt = 0; frame_len = 5;
        n_tests = 0; n_fail = 0; mcount = 0; cycle = 0; dv_total = 0; acc_total = 0;
        last_dv_tick = -1; last_done_tick = -1; wr_tick = 0; base = 0;
        prev_dv = 1'b0; gap_chk = 1'b0;

        tick();
        tick();
        check("reset_tx_dv", int'(o_Tx_DV), 0);
        check("reset_tx_byte", int'(o_Tx_Byte), 0);
        check("reset_empty", int'(o_Empty), 1);
        rst = 1'b0;
        tick();

        // Single byte: launch visible in the cycle after the edge following the write.
        auto_en   = 1'b1;
        frame_len = 5;
        write_byte(8'hA5);
        wr_tick = cycle;
        check("t1_count_one", int'(o_Count), 1);
        tick();
        check("t1_dv_latency", last_dv_tick - wr_tick, 1);
        check("t1_byte", int'(o_Tx_Byte), 8'hA5);
        wait_drain(200);
        check("t1_empty", int'(o_Empty), 1);

        // Burst of five with long frames; each launch three clocks after Done.
        frame_len      = 100;
        gap_chk        = 1'b1;
        last_done_tick = -1;
        base           = dv_total;
        for (int i = 1; i <= 5; i++) write_byte(8'(i));
        wait_drain(2000);
        gap_chk = 1'b0;
        check("t2_pulses", dv_total - base, 5);

        // Fill with Done held low: first byte launched, 16 stored, 18th dropped.
        auto_en    = 1'b0;
        man_active = 1'b0;
        man_done   = 1'b0;
        for (int i = 0; i < 17; i++) write_byte(8'h40 + 8'(i));
        check("t3_full", int'(o_Full), 1);
        check("t3_count16", int'(o_Count), 16);
        write_byte(8'hEE);
        check("t3_overflow", int'(o_Overflow), 1);
        check("t3_count_hold", int'(o_Count), 16);
        tick();
        check("t3_overflow_pulse", int'(o_Overflow), 0);
        man_done = 1'b1;
        tick();
        man_done  = 1'b0;
        auto_en   = 1'b1;
        frame_len = 3;
        wait_drain(2000);

        // Active held high from reset blocks launch; first edge seeing it low launches.
        auto_en    = 1'b0;
        man_active = 1'b1;
        async_reset();
        base = dv_total;
        write_byte(8'h3C);
        repeat (10) tick();
        check("t4_no_dv_while_active", dv_total - base, 0);
        man_active = 1'b0;
        wr_tick    = cycle;
        tick();
        check("t4_dv_after_active", last_dv_tick - wr_tick, 1);
        check("t4_pulses", dv_total - base, 1);
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        repeat (4) tick();

        // Wrap-around stream with interleaved drains.
        auto_en   = 1'b1;
        frame_len = 2;
        base      = acc_total;
        for (int i = 0; i < 40; i++) begin
            write_byte(8'(i * 7));
            if (i >= 6) repeat ((i % 4) * 2 + 1) tick();
        end
        wait_drain(2000);
        check("t5_all_accepted", acc_total - base, 40);

        // Reset mid-frame with three bytes queued; the stray Done must not launch anything.
        frame_len = 20;
        for (int i = 0; i < 4; i++) write_byte(8'hD0 + 8'(i));
        repeat (5) tick();
        check("t6_queued", int'(o_Count), 3);
        base = dv_total;
        async_reset();
        repeat (40) tick();
        check("t6_no_dv_after_reset", dv_total - base, 0);
        write_byte(8'h77);
        wait_drain(200);
        check("t6_new_write_sent", dv_total - base, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
